// File: rtl/sysid_pkg.sv
// sysid_pkg: shared definitions for the system-ID boot checker.
//   state_t               - sequencer states (also exported as a debug output)
//   SYSID_ADDR_ID/_TS     - word addresses of the ID and timestamp registers
//   EXPECTED_*_DEFAULT    - default expected contents of those registers
package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_ID = 3'd1,
        ST_LAT_ID = 3'd2,
        ST_REQ_TS = 3'd3,
        ST_LAT_TS = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] EXPECTED_ID_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXPECTED_TS_DEFAULT = 32'h6045_2F0D;

endpackage

// File: rtl/sysid_checker_if.sv
// sysid_checker_if: Avalon-MM read-only bus between the checker (master)
// and the system-ID slave.
//   avm_address     master -> slave  word address (0 = ID, 1 = timestamp)
//   avm_read        master -> slave  read request
//   avm_waitrequest slave -> master  stall
//   avm_readdata    slave -> master  read data
//
// Handshake: a read is accepted in the cycle where avm_read=1 and
// avm_waitrequest=0. While avm_read=1 and avm_waitrequest=1 the master holds
// avm_read and avm_address unchanged. readdata is valid READ_LATENCY cycles
// after the acceptance cycle (in the acceptance cycle itself when 0).
interface sysid_checker_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/sysid_checker_avm_read_port.sv
// avm_read_port: one Avalon-MM read at a time with a fixed read latency.
//   clock, reset  system clock, asynchronous active-high reset
//   req_i         hold high to request a read (driven from a register)
//   addr_i        word address, held with req_i
//   accept_o      the request is accepted this cycle
//   ack_o         readdata is valid this cycle (capture now)
//   data_o        readdata passthrough
//   avm           bus master side
module avm_read_port #(
    parameter int READ_LATENCY = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_i,
    input  logic                   addr_i,
    output logic                   accept_o,
    output logic                   ack_o,
    output logic [31:0]            data_o,
    sysid_checker_if.master        avm
);

    localparam logic [1:0] LAT_W = 2'(READ_LATENCY);

    logic [1:0] lat_q;

    assign avm.avm_read    = req_i;
    assign avm.avm_address = addr_i;
    assign accept_o        = req_i & ~avm.avm_waitrequest;
    assign data_o          = avm.avm_readdata;

    // lat_q counts the cycles after acceptance (1..READ_LATENCY); 0 = idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_q <= 2'd0;
        end else if (accept_o && READ_LATENCY != 0) begin
            lat_q <= 2'd1;
        end else if (lat_q != 2'd0) begin
            lat_q <= (lat_q == LAT_W) ? 2'd0 : lat_q + 2'd1;
        end
    end

    // Zero latency: data arrives with the acceptance itself.
    assign ack_o = (READ_LATENCY == 0) ? accept_o : (lat_q == LAT_W);

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: boot-time sanity gate that reads the system-ID slave
// (word 0 = ID, word 1 = build timestamp) and compares both words.
//   clock, reset        system clock, asynchronous active-high reset
//   start               one-cycle pulse, sampled only in IDLE
//   avm                 Avalon-MM read master (sysid_checker_if.master)
//   busy                sequence in progress
//   done                sticky completion flag, cleared by the next start
//   pass                both words matched (valid with done)
//   err_id, err_ts      per-field mismatch flags
//   id_value, ts_value  captured words
//   timeout             (SYSID_CHECK_TIMEOUT_EN only) stall limit hit
//   dbg_state           current sequencer state
// Optional feature macro: SYSID_CHECK_TIMEOUT_EN adds a per-read
// waitrequest stall limit (TIMEOUT_CYCLES) and the timeout output.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = EXPECTED_ID_DEFAULT,
    parameter logic [31:0] EXPECTED_TS  = EXPECTED_TS_DEFAULT,
    parameter int          READ_LATENCY = 0
`ifdef SYSID_CHECK_TIMEOUT_EN
  , parameter int          TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    sysid_checker_if.master        avm,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   err_id,
    output logic                   err_ts,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value,
`ifdef SYSID_CHECK_TIMEOUT_EN
    output logic                   timeout,
`endif
    output state_t                 dbg_state
);

    state_t      state_q;
    logic        read_q, addr_q;
    logic        busy_q, done_q, pass_q, err_id_q, err_ts_q;
    logic [31:0] id_q, ts_q;
    logic        accept, ack;
    logic [31:0] rdata;
    logic        stall_hit;

    avm_read_port #(.READ_LATENCY(READ_LATENCY)) u_port (
        .clock    (clock),
        .reset    (reset),
        .req_i    (read_q),
        .addr_i   (addr_q),
        .accept_o (accept),
        .ack_o    (ack),
        .data_o   (rdata),
        .avm      (avm)
    );

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_q;
    logic        tmo_q;

    // Counts stalled request cycles; cleared by acceptance and outside REQ_*.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if (read_q && avm.avm_waitrequest && !stall_hit) begin
            stall_q <= stall_q + 16'd1;
        end else begin
            stall_q <= 16'd0;
        end
    end

    assign stall_hit = read_q & avm.avm_waitrequest & (stall_q == STALL_LIMIT);
    assign timeout   = tmo_q;
`else
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            read_q   <= 1'b0;
            addr_q   <= SYSID_ADDR_ID;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_id_q <= 1'b0;
            err_ts_q <= 1'b0;
            id_q     <= 32'd0;
            ts_q     <= 32'd0;
`ifdef SYSID_CHECK_TIMEOUT_EN
            tmo_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_REQ_ID;
                        read_q   <= 1'b1;
                        addr_q   <= SYSID_ADDR_ID;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        err_id_q <= 1'b0;
                        err_ts_q <= 1'b0;
                        id_q     <= 32'd0;
                        ts_q     <= 32'd0;
`ifdef SYSID_CHECK_TIMEOUT_EN
                        tmo_q    <= 1'b0;
`endif
                    end
                end
                ST_REQ_ID, ST_LAT_ID: begin
                    if (ack) begin
                        id_q    <= rdata;
                        state_q <= ST_REQ_TS;
                        read_q  <= 1'b1;
                        addr_q  <= SYSID_ADDR_TS;
                    end else if (accept) begin
                        state_q <= ST_LAT_ID;
                        read_q  <= 1'b0;
                    end else if (stall_hit) begin
                        state_q  <= ST_DONE;
                        read_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_id_q <= 1'b1;
`ifdef SYSID_CHECK_TIMEOUT_EN
                        tmo_q    <= 1'b1;
`endif
                    end
                end
                ST_REQ_TS, ST_LAT_TS: begin
                    // Flags are resolved on the way into DONE so that done and
                    // the verdict become visible together in the DONE cycle.
                    if (ack) begin
                        ts_q     <= rdata;
                        state_q  <= ST_DONE;
                        read_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_id_q <= (id_q != EXPECTED_ID);
                        err_ts_q <= (rdata != EXPECTED_TS);
                        pass_q   <= (id_q == EXPECTED_ID) && (rdata == EXPECTED_TS);
                    end else if (accept) begin
                        state_q <= ST_LAT_TS;
                        read_q  <= 1'b0;
                    end else if (stall_hit) begin
                        state_q  <= ST_DONE;
                        read_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_id_q <= (id_q != EXPECTED_ID);
                        err_ts_q <= 1'b1;
`ifdef SYSID_CHECK_TIMEOUT_EN
                        tmo_q    <= 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_id    = err_id_q;
    assign err_ts    = err_ts_q;
    assign id_value  = id_q;
    assign ts_value  = ts_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two instances (READ_LATENCY 0 and 2) against
// behavioural Avalon slaves, with a per-instance expected queue and monitor.
module tb_sysid_checker;

    localparam logic [31:0] MODEL_EXP_ID = 32'h0000_0000;
    localparam logic [31:0] MODEL_EXP_TS = 32'h6045_2F0D;
    localparam int          TMO          = 16;

    typedef struct packed {
        logic        pass;
        logic        err_id;
        logic        err_ts;
        logic        tmo;
        logic [31:0] id;
        logic [31:0] ts;
        int          len;
        int          reads;
        int          t0;
    } exp_t;

    exp_t exp_q [2][$];

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  start_v = 2'b00;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt [2] = '{0, 0};
    logic [31:0] word_cfg [2] = '{32'd0, 32'd0};
    int          st_cfg [2] = '{0, 0};
    bit          allow_drop = 1'b0;

    logic        busy_w [2], done_w [2], pass_w [2], eid_w [2], ets_w [2];
    logic        rd_w [2], ad_w [2], tmo_w [2];
    logic [31:0] idv_w [2], tsv_w [2];
    sysid_pkg::state_t st_w [2];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference model: verdict and timing computed from the check rules.
    function automatic exp_t model(input logic [31:0] id_w, input logic [31:0] ts_w,
                                   input int s0, input int s1, input int lat,
                                   input bit tmo, input int t0);
        exp_t e;
        e.t0 = t0;
        if (tmo) begin
            e.pass = 1'b0; e.err_id = 1'b1; e.err_ts = 1'b0; e.tmo = 1'b1;
            e.id = 32'd0; e.ts = 32'd0; e.len = 1 + TMO; e.reads = 0;
        end else begin
            e.err_id = (id_w != MODEL_EXP_ID);
            e.err_ts = (ts_w != MODEL_EXP_TS);
            e.pass   = !(e.err_id || e.err_ts);
            e.tmo    = 1'b0;
            e.id     = id_w;
            e.ts     = ts_w;
            // start cycle + one request cycle per word + DONE, plus stalls/latency
            e.len    = 3 + s0 + s1 + 2 * lat;
            e.reads  = 2;
        end
        return e;
    endfunction

    // ---------------- DUTs, slave models, monitors ----------------
    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_inst
            localparam int LAT = g * 2;

            sysid_checker_if bus ();

            sysid_checker #(
                .READ_LATENCY (LAT)
`ifdef SYSID_CHECK_TIMEOUT_EN
              , .TIMEOUT_CYCLES (TMO)
`endif
            ) dut (
                .clock     (clock),
                .reset     (reset),
                .start     (start_v[g]),
                .avm       (bus.master),
                .busy      (busy_w[g]),
                .done      (done_w[g]),
                .pass      (pass_w[g]),
                .err_id    (eid_w[g]),
                .err_ts    (ets_w[g]),
                .id_value  (idv_w[g]),
                .ts_value  (tsv_w[g]),
`ifdef SYSID_CHECK_TIMEOUT_EN
                .timeout   (tmo_w[g]),
`endif
                .dbg_state (st_w[g])
            );

`ifndef SYSID_CHECK_TIMEOUT_EN
            assign tmo_w[g] = 1'b0;
`endif
            assign rd_w[g] = bus.avm_read;
            assign ad_w[g] = bus.avm_address;

            int          stall_left = 0;
            int          pend_cnt = 0;
            int          nreads = 0;
            logic [31:0] pend_word = 32'd0;
            bit          in_req = 1'b0;
            bit          prev_stall = 1'b0;
            bit          prev_addr = 1'b0;
            bit          prev_done = 1'b0;

            initial begin
                bus.avm_waitrequest = 1'b0;
                bus.avm_readdata    = 32'd0;
            end

            always @(negedge clock) begin
                logic [31:0] rdata;
                logic        w;
                exp_t        e;
                rdata = $urandom;
                w     = 1'b0;
                if (reset) begin
                    in_req = 0; pend_cnt = 0; nreads = 0;
                    prev_stall = 0; prev_done = 0;
                end else begin
                    if (prev_stall && !allow_drop) begin
                        check($sformatf("L%0d_read_held", LAT), bus.avm_read, 1);
                        check($sformatf("L%0d_addr_held", LAT), bus.avm_address, prev_addr);
                    end
                    if (!busy_w[g])
                        check($sformatf("L%0d_read_when_idle", LAT), bus.avm_read, 0);
                    // fixed-latency read pipeline: data only in its exact cycle
                    if (pend_cnt > 0) begin
                        pend_cnt--;
                        if (pend_cnt == 0) rdata = pend_word;
                    end
                    if (!bus.avm_read) begin
                        in_req = 0;
                    end else begin
                        if (!in_req) begin
                            in_req = 1;
                            stall_left = st_cfg[bus.avm_address];
                        end
                        if (stall_left > 0) begin
                            w = 1'b1;
                            stall_left--;
                        end else begin
                            in_req = 0;
                            check($sformatf("L%0d_addr_order", LAT), bus.avm_address, nreads);
                            nreads++;
                            if (LAT == 0) rdata = word_cfg[bus.avm_address];
                            else begin
                                pend_cnt  = LAT;
                                pend_word = word_cfg[bus.avm_address];
                            end
                        end
                    end
                    prev_stall = bus.avm_read && w;
                    prev_addr  = bus.avm_address;
                    // monitor: compare on each rising done
                    if (done_w[g] && !prev_done) begin
                        check($sformatf("L%0d_done_expected", LAT), exp_q[g].size() != 0, 1);
                        if (exp_q[g].size() != 0) begin
                            e = exp_q[g].pop_front();
                            check($sformatf("L%0d_pass", LAT), pass_w[g], e.pass);
                            check($sformatf("L%0d_err_id", LAT), eid_w[g], e.err_id);
                            check($sformatf("L%0d_err_ts", LAT), ets_w[g], e.err_ts);
                            check($sformatf("L%0d_id_value", LAT), idv_w[g], e.id);
                            check($sformatf("L%0d_ts_value", LAT), tsv_w[g], e.ts);
                            check($sformatf("L%0d_busy_at_done", LAT), busy_w[g], 0);
                            check($sformatf("L%0d_reads", LAT), nreads, e.reads);
                            check($sformatf("L%0d_done_cycle", LAT), cyc - e.t0, e.len);
`ifdef SYSID_CHECK_TIMEOUT_EN
                            check($sformatf("L%0d_timeout", LAT), tmo_w[g], e.tmo);
`endif
                        end
                        nreads = 0;
                        done_cnt[g]++;
                    end
                    prev_done = done_w[g];
                end
                bus.avm_waitrequest = w;
                bus.avm_readdata    = rdata;
            end
        end
    endgenerate

    // ---------------- driver tasks ----------------
    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("L%0d_%s_ctrl", i * 2, tag),
                  {busy_w[i], done_w[i], pass_w[i], eid_w[i], ets_w[i], rd_w[i], ad_w[i], tmo_w[i]}, 0);
            check($sformatf("L%0d_%s_id", i * 2, tag), idv_w[i], 0);
            check($sformatf("L%0d_%s_ts", i * 2, tag), tsv_w[i], 0);
        end
    endtask

    task automatic run_seq(input logic [31:0] id_w, input logic [31:0] ts_w,
                           input int s0, input int s1, input bit poke, input bit tmo);
        exp_t e0, e1;
        int   t0, tgt0, tgt1, lmax;
        word_cfg[0] = id_w; word_cfg[1] = ts_w;
        st_cfg[0] = s0;     st_cfg[1] = s1;
        allow_drop = tmo;
        @(negedge clock);
        t0 = cyc;
        e0 = model(id_w, ts_w, s0, s1, 0, tmo, t0);
        e1 = model(id_w, ts_w, s0, s1, 2, tmo, t0);
        exp_q[0].push_back(e0);
        exp_q[1].push_back(e1);
        tgt0 = done_cnt[0] + 1;
        tgt1 = done_cnt[1] + 1;
        lmax = (e0.len > e1.len) ? e0.len : e1.len;
        start_v = 2'b11;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clock);
            // extra pulses while busy and in each instance's DONE cycle
            start_v[0] = poke && (n == 1 || n == e0.len);
            start_v[1] = poke && (n == 1 || n == e1.len);
            if (done_cnt[0] >= tgt0 && done_cnt[1] >= tgt1 && n >= lmax + 3) break;
            if (n == 400) check("sequence_completes", 0, 1);
        end
        start_v = 2'b00;
        allow_drop = 1'b0;
    endtask

    task automatic reset_mid_ts();
        exp_t e0;
        int   s0, s1, tgt0;
        s0 = $urandom_range(0, 3);
        s1 = $urandom_range(0, 3);
        word_cfg[0] = MODEL_EXP_ID; word_cfg[1] = MODEL_EXP_TS;
        st_cfg[0] = s0;             st_cfg[1] = s1;
        @(negedge clock);
        e0 = model(MODEL_EXP_ID, MODEL_EXP_TS, s0, s1, 0, 1'b0, cyc);
        exp_q[0].push_back(e0);
        tgt0 = done_cnt[0] + 1;
        start_v = 2'b11;
        // first LAT_TS cycle of the latency-2 instance
        for (int n = 1; n <= 5 + s0 + s1; n++) begin
            @(negedge clock);
            start_v = 2'b00;
        end
        check("L2_busy_before_reset", busy_w[1], 1);
        check("L0_done_before_reset", done_cnt[0] >= tgt0, 1);
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        repeat (2) @(negedge clock);
        check_zero("held_reset");
        reset = 1'b0;
        @(negedge clock);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_zero("in_reset");
        reset = 1'b0;
        @(negedge clock);
        check_zero("after_reset");

        run_seq(MODEL_EXP_ID, MODEL_EXP_TS, 0, 0, 1'b0, 1'b0);
        run_seq(32'h0000_0001, MODEL_EXP_TS, 0, 0, 1'b0, 1'b0);
        run_seq(MODEL_EXP_ID, MODEL_EXP_TS, 5, 5, 1'b0, 1'b0);
        run_seq(MODEL_EXP_ID, 32'h6045_2F0C, 1, 3, 1'b0, 1'b0);
        run_seq(32'hFFFF_FFFF, 32'h0000_0000, 2, 0, 1'b0, 1'b0);
        run_seq(MODEL_EXP_ID, MODEL_EXP_TS, 2, 1, 1'b1, 1'b0);

        reset_mid_ts();
        run_seq(MODEL_EXP_ID, MODEL_EXP_TS, 0, 2, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] id_r, ts_r;
            id_r = ($urandom_range(0, 1) == 0) ? MODEL_EXP_ID : $urandom;
            ts_r = ($urandom_range(0, 1) == 0) ? MODEL_EXP_TS : $urandom;
            run_seq(id_r, ts_r, $urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(0, 3) == 0, 1'b0);
        end

`ifdef SYSID_CHECK_TIMEOUT_EN
        run_seq(MODEL_EXP_ID, MODEL_EXP_TS, 1000, 0, 1'b0, 1'b1);
        run_seq(MODEL_EXP_ID, MODEL_EXP_TS, 0, 0, 1'b0, 1'b0);
`endif

        repeat (4) @(negedge clock);
        for (int i = 0; i < 2; i++)
            check($sformatf("L%0d_queue_drained", i * 2), exp_q[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
